// File: rtl/tdm_pkg.sv
// Shared TDM link definitions: FSM encoding, default frame geometry and the
// slot-index width helper, used by both the receive demux and the transmit mux.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } tdm_state_e;

  localparam int TDM_NUM_CH = 4;
  localparam int TDM_DATA_W = 4;

  // A single-channel link still needs a 1-bit index to keep port widths legal.
  function automatic int tdm_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-NUM_CH slot counter: clear beats load-to-1, which beats increment.
// Registered count, no stall handling of its own; the caller gates en_i.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int NUM_CH = TDM_NUM_CH,
  parameter int IW     = tdm_idx_w(TDM_NUM_CH)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          en_i,
  input  logic          load1_i,
  input  logic          clr_i,
  output logic [IW-1:0] cnt_o,
  output logic          tc_o
);

  logic [IW-1:0] cnt_q;
  logic [IW-1:0] cnt_d;

  assign tc_o  = (cnt_q == IW'(NUM_CH - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = IW'(1);
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + IW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demux: steers shared-bus words into per-channel slots and publishes
// whole frames one clock after the last word; din_valid=0 stalls all state.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NUM_CH = TDM_NUM_CH,
  parameter int DATA_W = TDM_DATA_W
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       din_valid,
  input  logic                       din_sync,
  input  logic [DATA_W-1:0]          din,
  output logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic                       frame_valid,
  output logic                       frame_err,
  output logic [$clog2(NUM_CH)-1:0]  ch_idx,
  output logic                       locked
);

  localparam int IW = $clog2(NUM_CH);

  tdm_state_e state_q;
  tdm_state_e state_d;

  logic [IW-1:0] idx;
  logic          tc;
  logic          cnt_en;
  logic          cnt_load1;
  logic          cnt_clr;
  logic          shadow_wr;
  logic          publish;
  logic          err;
  logic [IW-1:0] wr_slot;

  // The last slot never needs a shadow: it is taken straight from din on publish.
  logic [NUM_CH-2:0][DATA_W-1:0] shadow_q;
  logic [NUM_CH-2:0][DATA_W-1:0] shadow_d;
  logic [NUM_CH*DATA_W-1:0]      ch_data_q;
  logic [NUM_CH*DATA_W-1:0]      ch_data_d;
  logic                          frame_valid_q;
  logic                          frame_err_q;

  tdm_slot_counter #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_slot_counter (
    .clock   (clock),
    .resetn  (resetn),
    .en_i    (cnt_en),
    .load1_i (cnt_load1),
    .clr_i   (cnt_clr),
    .cnt_o   (idx),
    .tc_o    (tc)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (din_valid) begin
      case (state_q)
        HUNT:    if (din_sync) state_d = RECV;
        RECV:    if (!din_sync && idx == '0) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    cnt_en    = 1'b0;
    cnt_load1 = 1'b0;
    cnt_clr   = 1'b0;
    shadow_wr = 1'b0;
    publish   = 1'b0;
    err       = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (din_sync) begin
            cnt_load1 = 1'b1;
            shadow_wr = 1'b1;
          end
        end
        RECV: begin
          if (din_sync) begin
            // A sync anywhere but slot 0 abandons the partial frame and restarts.
            cnt_load1 = 1'b1;
            shadow_wr = 1'b1;
            err       = (idx != '0);
          end else if (idx == '0) begin
            err     = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_en    = 1'b1;
            publish   = tc;
            shadow_wr = !tc;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_slot = din_sync ? '0 : idx;

  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < NUM_CH - 1; k++) begin
      if (shadow_wr && wr_slot == IW'(k)) begin
        shadow_d[k] = din;
      end
    end
    ch_data_d = publish ? {din, shadow_q} : ch_data_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shadow_q      <= '0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      ch_data_q     <= ch_data_d;
      frame_valid_q <= publish;
      frame_err_q   <= err;
    end
  end

  assign ch_data     = ch_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign ch_idx      = idx;
  assign locked      = (state_q == RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: a 4x4 instance for framing scenarios and a 2x8
// instance for the mid-frame reset case.
module tb_tdm_demux;

  logic        clock;
  logic        resetn;

  logic        din_valid;
  logic        din_sync;
  logic [3:0]  din;
  logic [15:0] ch_data;
  logic        frame_valid;
  logic        frame_err;
  logic [1:0]  ch_idx;
  logic        locked;

  logic        v2;
  logic        s2;
  logic [7:0]  d2;
  logic [15:0] ch_data2;
  logic        fv2;
  logic        fe2;
  logic [0:0]  idx2;
  logic        locked2;

  int checks;
  int failures;

  tdm_demux #(.NUM_CH(4), .DATA_W(4)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .din_valid   (din_valid),
    .din_sync    (din_sync),
    .din         (din),
    .ch_data     (ch_data),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .ch_idx      (ch_idx),
    .locked      (locked)
  );

  tdm_demux #(.NUM_CH(2), .DATA_W(8)) dut2 (
    .clock       (clock),
    .resetn      (resetn),
    .din_valid   (v2),
    .din_sync    (s2),
    .din         (d2),
    .ch_data     (ch_data2),
    .frame_valid (fv2),
    .frame_err   (fe2),
    .ch_idx      (idx2),
    .locked      (locked2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Called at posedge+1; returns at the next posedge+1 with outputs settled.
  task automatic step(input logic v, input logic s, input logic [3:0] d);
    din_valid = v;
    din_sync  = s;
    din       = d;
    @(posedge clock);
    #1;
  endtask

  task automatic step2(input logic v, input logic s, input logic [7:0] d);
    v2 = v;
    s2 = s;
    d2 = d;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (ch_data !== 16'h0000 || locked !== 1'b0 || ch_idx !== 2'd0 ||
        frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: ch_data=%h locked=%b idx=%0d fv=%b fe=%b, want 0000/0/0/0/0",
               ch_data, locked, ch_idx, frame_valid, frame_err);
    end
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 4'h0);
      checks++;
      if (ch_data !== 16'h0000 || locked !== 1'b0 || ch_idx !== 2'd0 ||
          frame_valid !== 1'b0 || frame_err !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold[%0d]: ch_data=%h locked=%b idx=%0d fv=%b fe=%b, want 0000/0/0/0/0",
                 i, ch_data, locked, ch_idx, frame_valid, frame_err);
      end
    end
    checks++;
    if (ch_data2 !== 16'h0000 || locked2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state2: ch_data=%h locked=%b, want 0000/0", ch_data2, locked2);
    end
  endtask

  task automatic test_clean_frame;
    step(1'b1, 1'b1, 4'hA);
    checks++;
    if (locked !== 1'b1 || ch_idx !== 2'd1 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL clean_after_A: locked=%b idx=%0d fv=%b, want 1/1/0", locked, ch_idx, frame_valid);
    end
    step(1'b1, 1'b0, 4'hB);
    step(1'b1, 1'b0, 4'hC);
    checks++;
    if (ch_idx !== 2'd3 || ch_data !== 16'h0000 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL clean_partial: idx=%0d ch_data=%h fv=%b, want 3/0000/0", ch_idx, ch_data, frame_valid);
    end
    step(1'b1, 1'b0, 4'hD);
    checks++;
    if (ch_data !== 16'hDCBA || frame_valid !== 1'b1 || ch_idx !== 2'd0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL clean_publish: ch_data=%h fv=%b idx=%0d locked=%b, want DCBA/1/0/1",
               ch_data, frame_valid, ch_idx, locked);
    end
    step(1'b0, 1'b0, 4'h0);
    checks++;
    if (frame_valid !== 1'b0 || ch_data !== 16'hDCBA || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL clean_pulse_width: fv=%b ch_data=%h fe=%b, want 0/DCBA/0", frame_valid, ch_data, frame_err);
    end
  endtask

  task automatic test_stalls_back_to_back;
    logic [3:0] words [8];
    int pulses;
    logic [1:0] idx_before;
    words  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 0), words[i]);
      if (frame_valid === 1'b1) pulses++;
      if (i < 3) begin
        idx_before = ch_idx;
        step(1'b0, 1'b1, 4'hF);
        step(1'b0, 1'b0, 4'hE);
        if (frame_valid === 1'b1) pulses++;
        checks++;
        if (ch_idx !== idx_before || ch_idx !== 2'(i + 1) || frame_err !== 1'b0) begin
          failures++;
          $display("FAIL stall_idx[%0d]: idx=%0d fe=%b, want %0d/0", i, ch_idx, frame_err, i + 1);
        end
      end
    end
    checks++;
    if (ch_data !== 16'h4321 || frame_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: ch_data=%h fv=%b, want 4321/1", ch_data, frame_valid);
    end
    for (int i = 4; i < 8; i++) begin
      step(1'b1, (i == 4), words[i]);
      if (frame_valid === 1'b1) pulses++;
      if (i < 7) begin
        checks++;
        if (ch_data !== 16'h4321 || frame_err !== 1'b0) begin
          failures++;
          $display("FAIL b2b_hold[%0d]: ch_data=%h fe=%b, want 4321/0", i, ch_data, frame_err);
        end
      end
    end
    checks++;
    if (ch_data !== 16'h8765) begin
      failures++;
      $display("FAIL b2b_second: ch_data=%h, want 8765", ch_data);
    end
    step(1'b0, 1'b0, 4'h0);
    if (frame_valid === 1'b1) pulses++;
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL b2b_pulse_count: got %0d, want 2", pulses);
    end
  endtask

  task automatic test_early_sync;
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b0, 4'h3);
    step(1'b1, 1'b0, 4'h4);
    checks++;
    if (ch_data !== 16'h4321) begin
      failures++;
      $display("FAIL early_setup: ch_data=%h, want 4321", ch_data);
    end
    step(1'b1, 1'b1, 4'h9);
    step(1'b1, 1'b0, 4'h8);
    checks++;
    if (ch_idx !== 2'd2 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL early_pre: idx=%0d fe=%b, want 2/0", ch_idx, frame_err);
    end
    step(1'b1, 1'b1, 4'h7);
    checks++;
    if (frame_err !== 1'b1 || frame_valid !== 1'b0 || ch_data !== 16'h4321 ||
        ch_idx !== 2'd1 || locked !== 1'b1) begin
      failures++;
      $display("FAIL early_err: fe=%b fv=%b ch_data=%h idx=%0d locked=%b, want 1/0/4321/1/1",
               frame_err, frame_valid, ch_data, ch_idx, locked);
    end
    step(1'b1, 1'b0, 4'h6);
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL early_err_width: fe=%b, want 0", frame_err);
    end
    step(1'b1, 1'b0, 4'h5);
    step(1'b1, 1'b0, 4'h4);
    checks++;
    if (ch_data !== 16'h4567 || frame_valid !== 1'b1 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL early_recover: ch_data=%h fv=%b fe=%b, want 4567/1/0", ch_data, frame_valid, frame_err);
    end
  endtask

  task automatic test_missing_sync;
    step(1'b1, 1'b0, 4'h3);
    checks++;
    if (frame_err !== 1'b1 || locked !== 1'b0 || ch_idx !== 2'd0 ||
        ch_data !== 16'h4567 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL missing_err: fe=%b locked=%b idx=%0d ch_data=%h fv=%b, want 1/0/0/4567/0",
               frame_err, locked, ch_idx, ch_data, frame_valid);
    end
    step(1'b1, 1'b0, 4'h5);
    checks++;
    if (frame_err !== 1'b0 || locked !== 1'b0 || ch_idx !== 2'd0) begin
      failures++;
      $display("FAIL hunt_discard: fe=%b locked=%b idx=%0d, want 0/0/0", frame_err, locked, ch_idx);
    end
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b0, 4'h3);
    step(1'b1, 1'b0, 4'h4);
    checks++;
    if (ch_data !== 16'h4321 || frame_valid !== 1'b1 || locked !== 1'b1) begin
      failures++;
      $display("FAIL missing_relock: ch_data=%h fv=%b locked=%b, want 4321/1/1", ch_data, frame_valid, locked);
    end
    step(1'b0, 1'b0, 4'h0);
  endtask

  task automatic test_reset_mid_frame;
    step2(1'b1, 1'b1, 8'h33);
    step2(1'b1, 1'b0, 8'h44);
    checks++;
    if (ch_data2 !== 16'h4433 || fv2 !== 1'b1) begin
      failures++;
      $display("FAIL rst2_setup: ch_data=%h fv=%b, want 4433/1", ch_data2, fv2);
    end
    step2(1'b1, 1'b1, 8'hAA);
    checks++;
    if (locked2 !== 1'b1 || idx2 !== 1'b1) begin
      failures++;
      $display("FAIL rst2_partial: locked=%b idx=%0d, want 1/1", locked2, idx2);
    end
    v2 = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (ch_data2 !== 16'h0000 || locked2 !== 1'b0 || idx2 !== 1'b0 || fv2 !== 1'b0 || fe2 !== 1'b0) begin
      failures++;
      $display("FAIL rst2_async: ch_data=%h locked=%b idx=%0d fv=%b fe=%b, want 0000/0/0/0/0",
               ch_data2, locked2, idx2, fv2, fe2);
    end
    @(posedge clock);
    #1;
    resetn = 1'b1;
    step2(1'b1, 1'b1, 8'h11);
    checks++;
    if (ch_data2 !== 16'h0000 || fe2 !== 1'b0 || fv2 !== 1'b0) begin
      failures++;
      $display("FAIL rst2_no_pulse: ch_data=%h fv=%b fe=%b, want 0000/0/0", ch_data2, fv2, fe2);
    end
    step2(1'b1, 1'b0, 8'h22);
    checks++;
    if (ch_data2 !== 16'h2211 || fv2 !== 1'b1) begin
      failures++;
      $display("FAIL rst2_recover: ch_data=%h fv=%b, want 2211/1", ch_data2, fv2);
    end
    step2(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    resetn    = 1'b0;
    din_valid = 1'b0;
    din_sync  = 1'b0;
    din       = 4'h0;
    v2        = 1'b0;
    s2        = 1'b0;
    d2        = 8'h00;
    test_reset();
    test_clean_frame();
    test_stalls_back_to_back();
    test_early_sync();
    test_missing_sync();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
